// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into R/I/J words, queues them in a small FIFO
// and writes them to consecutive instruction-memory addresses over a req/ack port.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        fmt_err,
    output logic [15:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t       state_q;
    logic [31:0]  fifo_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [31:0]  addr_q;
    logic [15:0]  count_q;
    logic         err_q;

    logic [AW:0]  level;
    logic         empty;
    logic         full;
    logic         accept;
    logic         push;
    logic         pop;
    logic         last_pop;
    logic [31:0]  word_d;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready = (state_q == LOAD) && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (fmt != 2'd3);
    assign mem_req  = !empty;
    assign pop      = mem_req && mem_ack;
    // Lets DRAIN leave on the edge of the final ack instead of one cycle later.
    assign last_pop = pop && (level == (AW+1)'(1));

    assign mem_addr  = addr_q;
    assign mem_wdata = mem_req ? fifo_q[rd_ptr_q[AW-1:0]] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign fmt_err   = err_q;
    assign count     = count_q;

    always_comb begin
        word_d = '0;
        case (fmt)
            2'd0:    word_d = {op, rs, rt, rd, shamt, funct};
            2'd1:    word_d = {op, rs, rt, imm};
            2'd2:    word_d = {op, target};
            default: word_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= word_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                addr_q   <= addr_q + 32'd4;
                count_q  <= count_q + 16'd1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        addr_q   <= base_addr;
                        count_q  <= '0;
                        err_q    <= 1'b0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                    end
                end
                LOAD: begin
                    if (accept && (fmt == 2'd3)) begin
                        err_q <= 1'b1;
                    end
                    if (accept && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty || last_pop) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encoding, backpressure, illegal format,
// mid-session reset and address wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        fmt_err;
    logic [15:0] count;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int ncap = 0;
    logic [31:0] cap_addr [64];
    logic [31:0] cap_data [64];
    int          cap_cyc  [64];

    instr_encoder #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .fmt_err(fmt_err),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && mem_req && mem_ack && ncap < 64) begin
            cap_addr[ncap] <= mem_addr;
            cap_data[ncap] <= mem_wdata;
            cap_cyc[ncap]  <= cyc;
            ncap           <= ncap + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        tick;
        start = 1'b0;
        nvec++;
        if ({busy, in_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL start_ready: busy,in_ready=%b want 11", {busy, in_ready});
        end
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im,
                        input logic [25:0] tg, input logic last);
        bit acc = 0;
        in_valid = 1'b1; fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh;
        funct = fn; imm = im; target = tg; in_last = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (in_ready) acc = 1;
            tick;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: in_ready never 1 within 50 cycles, want accept");
        end
    endtask

    // R word: op=0 rs=1 rt=2 rd=d shamt=0 funct=0x20 -> 0x00220020 | d<<11
    task automatic send_r(input logic [4:0] d, input logic last);
        send(2'd0, 6'd0, 5'd1, 5'd2, d, 5'd0, 6'h20, 16'd0, 26'd0, last);
    endtask

    task automatic wait_done;
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done) found = 1;
            else tick;
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL done_seen: done=0 after 40 cycles, want 1");
        end
        tick;
        nvec++;
        if ({done, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL after_done: done,busy=%b want 00", {done, busy});
        end
    endtask

    task automatic check_cap(input int idx, input logic [31:0] a, input logic [31:0] w);
        nvec++;
        if (idx >= ncap || cap_addr[idx] !== a || cap_data[idx] !== w) begin
            nerr++;
            $display("FAIL write[%0d]: got %h@%h (n=%0d) want %h@%h", idx,
                     cap_data[idx], cap_addr[idx], ncap, w, a);
        end
    endtask

    task automatic check_count(input logic [15:0] c);
        nvec++;
        if (count !== c) begin
            nerr++;
            $display("FAIL count: got %0d want %0d", count, c);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({in_ready, mem_req, busy, done, fmt_err, mem_addr, mem_wdata, count} !== '0) begin
            nerr++;
            $display("FAIL reset_state: rdy=%b req=%b busy=%b done=%b err=%b addr=%h wd=%h cnt=%0d want all 0",
                     in_ready, mem_req, busy, done, fmt_err, mem_addr, mem_wdata, count);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_r_single;
        int i0 = ncap;
        do_start(32'h100);
        mem_ack = 1'b1;
        send_r(5'd3, 1'b1);
        nvec++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'h00221820}) begin
            nerr++;
            $display("FAIL r_latency: req=%b addr=%h wd=%h want 1 00000100 00221820",
                     mem_req, mem_addr, mem_wdata);
        end
        tick;
        nvec++;
        if ({done, busy} !== 2'b11) begin
            nerr++;
            $display("FAIL done_timing: done,busy=%b want 11", {done, busy});
        end
        tick;
        nvec++;
        if ({done, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL idle_timing: done,busy=%b want 00", {done, busy});
        end
        check_cap(i0, 32'h100, 32'h00221820);
        check_count(16'd1);
        nvec++;
        if (fmt_err !== 1'b0) begin
            nerr++;
            $display("FAIL r_fmt_err: got %b want 0", fmt_err);
        end
    endtask

    task automatic test_i_j;
        int i0 = ncap;
        do_start(32'h0);
        send(2'd1, 6'h23, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
        wait_done;
        check_cap(i0, 32'h0, 32'h8D280004);
        check_cap(i0 + 1, 32'h4, 32'h08000010);
        check_count(16'd2);
    endtask

    task automatic test_backpressure;
        int i0 = ncap;
        int k = 0;
        bit rdy;
        do_start(32'h40);
        mem_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (k < 6) begin
                in_valid = 1'b1; fmt = 2'd0; op = 6'd0; rs = 5'd1; rt = 5'd2;
                rd = k[4:0]; shamt = 5'd0; funct = 6'h20; in_last = (k == 5);
            end
            rdy = in_ready;
            tick;
            if (rdy && k < 6) k++;
            if (k > 0) begin
                nvec++;
                if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h40, 32'h00220020}) begin
                    nerr++;
                    $display("FAIL bp_hold: req=%b addr=%h wd=%h want 1 00000040 00220020",
                             mem_req, mem_addr, mem_wdata);
                end
            end
        end
        nvec++;
        if (k != 4 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL bp_accepted: accepted=%0d in_ready=%b want 4 0", k, in_ready);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        mem_ack = 1'b1;
        send_r(5'd4, 1'b0);
        send_r(5'd5, 1'b1);
        wait_done;
        for (int j = 0; j < 6; j++) begin
            check_cap(i0 + j, 32'h40 + 32'(4 * j), 32'h00220020 | (32'(j) << 11));
        end
        for (int j = 0; j < 3; j++) begin
            nvec++;
            if (cap_cyc[i0 + j + 1] != cap_cyc[i0 + j] + 1) begin
                nerr++;
                $display("FAIL throughput[%0d]: cycle gap %0d want 1", j,
                         cap_cyc[i0 + j + 1] - cap_cyc[i0 + j]);
            end
        end
        check_count(16'd6);
    endtask

    task automatic test_illegal;
        int i0 = ncap;
        do_start(32'h80);
        send_r(5'd1, 1'b0);
        send(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send_r(5'd2, 1'b1);
        wait_done;
        check_cap(i0, 32'h80, 32'h00220820);
        check_cap(i0 + 1, 32'h84, 32'h00221020);
        nvec++;
        if (ncap != i0 + 2) begin
            nerr++;
            $display("FAIL illegal_writes: got %0d writes want 2", ncap - i0);
        end
        check_count(16'd2);
        nvec++;
        if (fmt_err !== 1'b1) begin
            nerr++;
            $display("FAIL illegal_sticky: fmt_err=%b want 1", fmt_err);
        end
    endtask

    task automatic test_wrap;
        int i0 = ncap;
        do_start(32'hFFFF_FFFC);
        nvec++;
        if (fmt_err !== 1'b0) begin
            nerr++;
            $display("FAIL err_clear: fmt_err=%b want 0", fmt_err);
        end
        send_r(5'd7, 1'b0);
        start = 1'b1;
        base_addr = 32'h1234;
        tick;
        start = 1'b0;
        send_r(5'd8, 1'b1);
        wait_done;
        check_cap(i0, 32'hFFFF_FFFC, 32'h00223820);
        check_cap(i0 + 1, 32'h0000_0000, 32'h00224020);
        check_count(16'd2);
    endtask

    task automatic test_reset_drain;
        int i0;
        do_start(32'h300);
        mem_ack = 1'b0;
        send_r(5'd1, 1'b0);
        send_r(5'd2, 1'b1);
        nvec++;
        if ({busy, mem_req, in_ready} !== 3'b110) begin
            nerr++;
            $display("FAIL drain_state: busy,req,rdy=%b want 110", {busy, mem_req, in_ready});
        end
        i0 = ncap;
        #2 rst = 1'b0;
        #1;
        nvec++;
        if ({in_ready, mem_req, busy, done, fmt_err, mem_addr, mem_wdata, count} !== '0) begin
            nerr++;
            $display("FAIL midreset_state: rdy=%b req=%b busy=%b done=%b err=%b addr=%h wd=%h cnt=%0d want all 0",
                     in_ready, mem_req, busy, done, fmt_err, mem_addr, mem_wdata, count);
        end
        mem_ack = 1'b1;
        tick;
        tick;
        nvec++;
        if (ncap != i0 || mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_nowrite: writes=%0d req=%b want 0 0", ncap - i0, mem_req);
        end
        rst = 1'b1;
        tick;
        i0 = ncap;
        do_start(32'h200);
        send_r(5'd3, 1'b1);
        wait_done;
        check_cap(i0, 32'h200, 32'h00221820);
        check_count(16'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        fmt = '0; op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
        imm = '0; target = '0; mem_ack = 1'b0;
        test_reset;
        test_r_single;
        test_i_j;
        test_backpressure;
        test_illegal;
        test_wrap;
        test_reset_drain;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader: the encode-side counterpart of the control unit's Op/funct/shamt decode. It accepts decoded instruction fields over a valid/ready stream, packs them into 32-bit R/I/J words, buffers them in a small FIFO, and writes them to consecutive instruction-memory addresses over a req/ack port. It sits in the test/boot path ahead of instruction memory and loads programs that the pipeline later fetches and decodes.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a load session (ignored unless IDLE)
- base_addr  in  32  first write address, sampled on accepted start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_last  in  1  bundle is last of program
- fmt  in  2  0=R, 1=I, 2=J, 3=illegal
- op  in  6  opcode
- rs, rt, rd  in  5 each  register fields
- shamt  in  5  shift amount
- funct  in  6  function code
- imm  in  16  immediate (I-format)
- target  in  26  jump target (J-format)
- mem_req  out  1  write request to instruction memory
- mem_addr  out  32  write address
- mem_wdata  out  32  encoded instruction word
- mem_ack  in  1  write accepted this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- fmt_err  out  1  sticky: an illegal fmt was seen this session
- count  out  16  words written (acked) this session

## Operation
- States: IDLE, LOAD, DRAIN, FIN.
- IDLE: start=1 → LOAD; next_addr←base_addr, count←0, fmt_err←0, FIFO pointers cleared.
- LOAD: in_ready = !full. Handshake on in_valid & in_ready. Accepted bundle with in_last=1 → DRAIN.
- DRAIN: in_ready=0; stays until FIFO empty and no mem_req pending → FIN.
- FIN: done=1 for exactly one cycle → IDLE.
- start in any state except IDLE is ignored.
- Encoding: R = {op,rs,rt,rd,shamt,funct}; I = {op,rs,rt,imm}; J = {op,target}. Unused fields ignored.
- fmt=3: bundle is accepted (handshake completes), nothing pushed, fmt_err←1. If in_last=1, LOAD→DRAIN still occurs.
- Memory side: mem_req = FIFO not empty; mem_wdata = FIFO head; mem_addr = next_addr. On mem_req & mem_ack: pop, next_addr += 4 (mod 2^32 wrap), count += 1 (mod 2^16 wrap).
- mem_req, mem_addr and mem_wdata are held stable while mem_req=1 and mem_ack=0.
- mem_ack with mem_req=0 is ignored.
- Full FIFO: in_ready=0; a pop in the same cycle does not allow a same-cycle push (in_ready depends on registered full only).
- Push and pop in the same cycle when neither full nor empty: both occur, occupancy unchanged.
- Reset (any time, including mid-session): state=IDLE, FIFO empty, in_ready=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, done=0, fmt_err=0, count=0. No write is completed after rst asserts.

## Timing
- Bundle accepted in cycle N → mem_req=1 with its word from cycle N+1 (FIFO registered, no pass-through).
- With mem_ack held high, sustained throughput is one word per cycle.
- start accepted in cycle N → busy=1 and in_ready=1 in cycle N+1.
- Final ack in cycle M (FIFO empty after it) → DRAIN to FIN at edge M+1, done=1 during cycle M+1, busy=0 from cycle M+2.
- in_ready, mem_req, busy, done are functions of registered state only; no combinational input→output paths except none on the memory side.

## Test plan
- start, base_addr=0x100; R: op=0 rs=1 rt=2 rd=3 shamt=0 funct=0x20, in_last=1; mem_ack=1 → one write 0x00221820 @0x100, count=1, done pulse, fmt_err=0.
- I: op=0x23 rs=9 rt=8 imm=4, then J: op=2 target=0x10 (last), base 0 → writes 0x8D280004 @0x0, 0x08000010 @0x4.
- Backpressure: mem_ack=0 for 10 cycles, 6 bundles offered → exactly DEPTH=4 accepted, in_ready=0, mem_addr/mem_wdata stable; release ack → all 6 written in order, count=6.
- Middle bundle fmt=3 among three → two writes at base, base+4; fmt_err=1 until next start; count=2.
- Assert rst during DRAIN with 2 words queued → all outputs at reset values next cycle; new start with base 0x200 writes from 0x200, count from 0.
- base_addr=0xFFFFFFFC, two words → addresses 0xFFFFFFFC then 0x00000000; start pulsed during LOAD has no effect.
